// File: rtl/comp_share_arbiter_pkg.sv
// Shared types and constants for the comparator-sharing arbiter.
package comp_pkg;
  localparam int CW       = 3;
  localparam int MAX_NREQ = 8;

  typedef enum logic {IDLE = 1'b0, EVAL = 1'b1} state_e;

  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    v[idx[2:0]] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/comp_share_arbiter_if.sv
// Request/grant/result bundle between the requesters and comp_share_arbiter.
interface comp_share_arbiter_if #(parameter int NREQ = 4);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]             req;
  logic [NREQ*comp_pkg::CW-1:0] a_in;
  logic [NREQ*comp_pkg::CW-1:0] b_in;
  logic [NREQ-1:0]             gnt;
  logic                        busy;
  logic                        done;
  logic [IW-1:0]               done_id;
  logic                        lt;
  logic                        eq;
  logic                        gt;

  modport master (output req, a_in, b_in,
                  input  gnt, busy, done, done_id, lt, eq, gt);
  modport slave  (input  req, a_in, b_in,
                  output gnt, busy, done, done_id, lt, eq, gt);
endinterface

// File: rtl/comp_share_arbiter_cmp.sv
// Unsigned 3-bit magnitude comparator shared by all requesters.
module comparator_3bit
  import comp_pkg::*;
(
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic          lt,
  output logic          eq,
  output logic          gt
);
  assign lt = (a <  b);
  assign eq = (a == b);
  assign gt = (a >  b);
endmodule

// File: rtl/comp_share_arbiter_picker.sv
// Winner selection from the request vector; CMP_FIXED_PRIO_EN selects
// lowest-index priority instead of round-robin after ptr.
module rr_picker #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   w
);
  logic [IW-1:0] idx;

`ifdef CMP_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    valid = 1'b0;
    w     = '0;
    idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = IW'(i);
      if (req[idx]) begin
        valid = 1'b1;
        w     = idx;
      end
    end
  end
`else
  // Scan from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    valid = 1'b0;
    w     = '0;
    idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NREQ);
      if (req[idx]) begin
        valid = 1'b1;
        w     = idx;
      end
    end
  end
`endif
endmodule

// File: rtl/comp_share_arbiter.sv
// Arbitrates NREQ requesters onto one comparator_3bit; registered flags + done.
// Build option CMP_FIXED_PRIO_EN: fixed lowest-index priority, ptr frozen.
module comp_share_arbiter
  import comp_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  comp_share_arbiter_if.slave  bus
);
  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic            load, finish;
  logic            pick_vld;
  logic [IW-1:0]   pick_w;
  logic [IW-1:0]   ptr_q, w_q, done_id_q;
  logic [CW-1:0]   opa_q, opb_q;
  logic            cmp_lt, cmp_eq, cmp_gt;
  logic            lt_q, eq_q, gt_q, done_q;
  logic [MAX_NREQ-1:0] oh_full;

  rr_picker #(.NREQ(NREQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .w     (pick_w)
  );

  comparator_3bit u_cmp (
    .a  (opa_q),
    .b  (opb_q),
    .lt (cmp_lt),
    .eq (cmp_eq),
    .gt (cmp_gt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (pick_vld) begin
        load    = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= IW'(NREQ - 1);
      w_q       <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
    end else begin
      done_q <= finish;
      if (load) begin
        w_q   <= pick_w;
        opa_q <= bus.a_in[32'(pick_w)*CW +: CW];
        opb_q <= bus.b_in[32'(pick_w)*CW +: CW];
      end
      if (finish) begin
        lt_q      <= cmp_lt;
        eq_q      <= cmp_eq;
        gt_q      <= cmp_gt;
        done_id_q <= w_q;
`ifndef CMP_FIXED_PRIO_EN
        ptr_q     <= w_q;
`endif
      end
    end
  end

  // Grant is the latched winner decoded for the whole EVAL cycle.
  assign oh_full = (state_q == EVAL) ? onehot(32'(w_q)) : '0;

  if (NREQ < MAX_NREQ) begin : g_unused_oh
    logic [MAX_NREQ-NREQ-1:0] unused_oh;
    assign unused_oh = oh_full[MAX_NREQ-1:NREQ];
  end

  assign bus.gnt     = oh_full[NREQ-1:0];
  assign bus.busy    = (state_q == EVAL);
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.lt      = lt_q;
  assign bus.eq      = eq_q;
  assign bus.gt      = gt_q;
endmodule
